// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 timing defaults and the sync-recovery FSM state
//   encoding. Usable by both the timing generator and vga_sync_decoder.
//   Contents:
//     DEF_H_* / DEF_V_*  default horizontal / vertical timing (clocks, lines)
//     sync_state_t       decoder lock state: SEARCH, MEASURE, LOCKED
package vga_timing_pkg;

   localparam int DEF_H_VIS   = 640;
   localparam int DEF_H_SYNC  = 96;
   localparam int DEF_H_BP    = 48;
   localparam int DEF_H_TOTAL = 800;

   localparam int DEF_V_VIS   = 480;
   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BP    = 33;
   localparam int DEF_V_TOTAL = 525;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } sync_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Registers an active-low sync input once (stage 1) and flags the
//   falling edge: stage-1 value now 0 while the previous stage-1 value was 1.
//   Ports:
//     clk   pixel clock
//     rst   synchronous active-high reset (both stages reset to idle-high)
//     din   raw sync input from the pins
//     fall  one-cycle pulse aligned with the stage-1 sample of the edge
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic fall
);

   logic stage1;
   logic stage1_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage1      <= 1'b1;
         stage1_prev <= 1'b1;
      end else begin
         stage1      <= din;
         stage1_prev <= stage1;
      end
   end

   assign fall = stage1_prev & ~stage1;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers pixel coordinates from an incoming VGA stream, checks that the
//   sync timing matches the parameters and reports lock / timing errors.
//   Ports:
//     clk, rst          pixel clock, synchronous active-high reset
//     HSync, VSync      incoming active-low syncs
//     rgb               incoming pixel colour
//     PixelX, PixelY    recovered visible coordinates (0 outside window)
//     PixelValid        locked and inside the visible window
//     rgb_out           colour of the pixel at PixelX/PixelY (0 if invalid)
//     FrameStart        pulse together with pixel (0,0)
//     Locked            timing matches the parameters
//     SyncErr           pulse on a timing violation while locked
//   Pin-to-output latency is two clocks.
module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int H_VIS   = DEF_H_VIS,
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BP    = DEF_H_BP,
   parameter int H_TOTAL = DEF_H_TOTAL,
   parameter int V_VIS   = DEF_V_VIS,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BP    = DEF_V_BP,
   parameter int V_TOTAL = DEF_V_TOTAL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       HSync,
   input  logic       VSync,
   input  logic [2:0] rgb,
   output logic [9:0] PixelX,
   output logic [9:0] PixelY,
   output logic       PixelValid,
   output logic [2:0] rgb_out,
   output logic       FrameStart,
   output logic       Locked,
   output logic       SyncErr
);

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_LIMIT = 10'(H_TOTAL);
   localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_VIS);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_LIMIT = 10'(V_TOTAL);
   localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_VIS);

   logic        hs_edge;
   logic        vs_edge;
   logic [2:0]  rgb_s1;
   logic [9:0]  hcnt;
   logic [9:0]  vcnt;
   logic        vpend;
   sync_state_t state;

   logic [9:0]  hcnt_nxt;
   logic [9:0]  vcnt_nxt;
   logic        vpend_nxt;
   logic        frame_evt;
   logic        line_fault;
   logic        frame_fault;
   logic        fault;
   logic        visible;
   sync_state_t state_nxt;

   sync_edge_det u_hs_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (HSync),
      .fall (hs_edge)
   );

   sync_edge_det u_vs_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (VSync),
      .fall (vs_edge)
   );

   // hcnt_nxt/vcnt_nxt are the coordinates of the sample currently in
   // stage 1; the registered hcnt/vcnt belong to the previous sample, which
   // is what the end-of-line / end-of-frame checks must look at.
   always_comb begin
      frame_evt = hs_edge & (vpend | vs_edge);
      vpend_nxt = frame_evt ? 1'b0 : (vpend | vs_edge);

      if (hs_edge)
         hcnt_nxt = '0;
      else if (hcnt == '1)
         hcnt_nxt = hcnt;
      else
         hcnt_nxt = hcnt + 10'd1;

      vcnt_nxt = vcnt;
      if (frame_evt)
         vcnt_nxt = '0;
      else if (hs_edge && vcnt != '1)
         vcnt_nxt = vcnt + 10'd1;

      line_fault  = hs_edge ? (hcnt != H_LAST) : (hcnt_nxt == H_LIMIT);
      frame_fault = frame_evt ? (vcnt != V_LAST)
                              : (hs_edge && vcnt_nxt == V_LIMIT);
      fault       = line_fault | frame_fault;

      state_nxt = state;
      case (state)
         SEARCH:  if (frame_evt) state_nxt = MEASURE;
         MEASURE: if (fault) state_nxt = SEARCH;
                  else if (frame_evt) state_nxt = LOCKED;
         LOCKED:  if (fault) state_nxt = SEARCH;
         default: state_nxt = SEARCH;
      endcase

      visible = (state_nxt == LOCKED) &&
                (hcnt_nxt >= H_START) && (hcnt_nxt < H_END) &&
                (vcnt_nxt >= V_START) && (vcnt_nxt < V_END);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_s1     <= '0;
         hcnt       <= '0;
         vcnt       <= '0;
         vpend      <= 1'b0;
         state      <= SEARCH;
         PixelX     <= '0;
         PixelY     <= '0;
         PixelValid <= 1'b0;
         rgb_out    <= '0;
         FrameStart <= 1'b0;
         Locked     <= 1'b0;
         SyncErr    <= 1'b0;
      end else begin
         rgb_s1     <= rgb;
         hcnt       <= hcnt_nxt;
         vcnt       <= vcnt_nxt;
         vpend      <= vpend_nxt;
         state      <= state_nxt;
         PixelValid <= visible;
         PixelX     <= visible ? hcnt_nxt - H_START : '0;
         PixelY     <= visible ? vcnt_nxt - V_START : '0;
         rgb_out    <= visible ? rgb_s1 : '0;
         FrameStart <= visible && (hcnt_nxt == H_START) && (vcnt_nxt == V_START);
         Locked     <= (state_nxt == LOCKED);
         SyncErr    <= (state == LOCKED) && fault;
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//   Scenario bench for vga_sync_decoder using a reduced timing set so that
//   many frames fit in a short run. A behavioural model of the decoding
//   rules predicts every output cycle; scenario tasks add directed checks.
module tb_vga_sync_decoder;

   localparam int TH_VIS = 20, TH_SYNC = 4, TH_BP = 6, TH_TOTAL = 34;
   localparam int TV_VIS = 10, TV_SYNC = 2, TV_BP = 3, TV_TOTAL = 18;
   localparam int HX0 = TH_SYNC + TH_BP;
   localparam int VY0 = TV_SYNC + TV_BP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       HSync = 1'b1;
   logic       VSync = 1'b1;
   logic [2:0] rgb = 3'd0;
   logic [9:0] PixelX, PixelY;
   logic       PixelValid, FrameStart, Locked, SyncErr;
   logic [2:0] rgb_out;

   vga_sync_decoder #(
      .H_VIS(TH_VIS), .H_SYNC(TH_SYNC), .H_BP(TH_BP), .H_TOTAL(TH_TOTAL),
      .V_VIS(TV_VIS), .V_SYNC(TV_SYNC), .V_BP(TV_BP), .V_TOTAL(TV_TOTAL)
   ) dut (
      .clk(clk), .rst(rst), .HSync(HSync), .VSync(VSync), .rgb(rgb),
      .PixelX(PixelX), .PixelY(PixelY), .PixelValid(PixelValid),
      .rgb_out(rgb_out), .FrameStart(FrameStart), .Locked(Locked),
      .SyncErr(SyncErr)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    failures = 0;
   int    mm_cnt, err_count, err_bad, fs_count, fs_bad;
   string mm_msg;

   // reference model: 0 = searching, 1 = measuring, 2 = locked
   logic       m_s1_hs, m_s1_vs, m_ph, m_pv;
   logic [2:0] m_s1_rgb;
   int         m_h, m_v, m_st;
   bit         m_vp;
   int         exp_x, exp_y;
   logic       exp_valid, exp_fs, exp_locked, exp_err;
   logic [2:0] exp_rgb;

   task automatic model_edge();
      bit hedge, vedge, fe, lf, ff, flt, vis;
      int nh, nv, nst;
      if (rst) begin
         m_s1_hs = 1; m_s1_vs = 1; m_s1_rgb = 0; m_ph = 1; m_pv = 1;
         m_h = 0; m_v = 0; m_vp = 0; m_st = 0;
         exp_x = 0; exp_y = 0; exp_valid = 0; exp_rgb = 0;
         exp_fs = 0; exp_locked = 0; exp_err = 0;
      end else begin
         hedge = (m_ph == 1'b1) && (m_s1_hs == 1'b0);
         vedge = (m_pv == 1'b1) && (m_s1_vs == 1'b0);
         m_ph = m_s1_hs;
         m_pv = m_s1_vs;
         fe = hedge && (m_vp || vedge);
         nh = hedge ? 0 : ((m_h + 1 > 1023) ? 1023 : m_h + 1);
         if (fe) nv = 0;
         else if (hedge) nv = (m_v + 1 > 1023) ? 1023 : m_v + 1;
         else nv = m_v;
         lf = hedge ? (m_h != TH_TOTAL - 1) : (nh == TH_TOTAL);
         ff = fe ? (m_v != TV_TOTAL - 1) : (hedge && nv == TV_TOTAL);
         flt = lf || ff;
         m_vp = fe ? 1'b0 : (m_vp || vedge);
         if (m_st == 0) nst = fe ? 1 : 0;
         else if (m_st == 1) nst = flt ? 0 : (fe ? 2 : 1);
         else nst = flt ? 0 : 2;
         exp_err = (m_st == 2) && flt;
         vis = (nst == 2) && nh >= HX0 && nh < HX0 + TH_VIS &&
               nv >= VY0 && nv < VY0 + TV_VIS;
         exp_valid = vis;
         exp_x = vis ? nh - HX0 : 0;
         exp_y = vis ? nv - VY0 : 0;
         exp_rgb = vis ? m_s1_rgb : 3'd0;
         exp_fs = vis && nh == HX0 && nv == VY0;
         exp_locked = (nst == 2);
         m_st = nst; m_h = nh; m_v = nv;
         m_s1_hs = HSync; m_s1_vs = VSync; m_s1_rgb = rgb;
      end
   endtask

   task automatic tick(input logic h, input logic v, input logic [2:0] c);
      HSync = h; VSync = v; rgb = c;
      @(posedge clk);
      model_edge();
      #1;
      if ({PixelX, PixelY, PixelValid, rgb_out, FrameStart, Locked, SyncErr} !==
          {10'(exp_x), 10'(exp_y), exp_valid, exp_rgb, exp_fs, exp_locked, exp_err}) begin
         if (mm_cnt == 0)
            mm_msg = $sformatf("t=%0t got X=%0d Y=%0d V=%b rgb=%0d FS=%b L=%b E=%b want X=%0d Y=%0d V=%b rgb=%0d FS=%b L=%b E=%b",
               $time, PixelX, PixelY, PixelValid, rgb_out, FrameStart, Locked, SyncErr,
               exp_x, exp_y, exp_valid, exp_rgb, exp_fs, exp_locked, exp_err);
         mm_cnt++;
      end
      if (SyncErr === 1'b1) begin
         err_count++;
         if (Locked !== 1'b0 || PixelValid !== 1'b0) err_bad++;
      end
      if (FrameStart === 1'b1) begin
         fs_count++;
         if (PixelX !== 10'd0 || PixelY !== 10'd0) fs_bad++;
      end
   endtask

   task automatic pix(input int line, input int col, input int len, input int nlines,
                      input int early, input bit stuck, input logic [2:0] c);
      logic h, v;
      h = (stuck || col >= TH_SYNC) ? 1'b1 : 1'b0;
      v = (line < TV_SYNC) ? 1'b0 : 1'b1;
      if (early > 0 && line == nlines - 1 && col >= len - early) v = 1'b0;
      tick(h, v, c);
   endtask

   task automatic send_line(input int line, input int c0, input int c1, input int len,
                            input int nlines, input int early, input bit stuck);
      for (int c = c0; c < c1; c++) pix(line, c, len, nlines, early, stuck, 3'($urandom));
   endtask

   task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                             input bit stuck, input int early);
      for (int l = 0; l < nlines; l++) begin
         int len;
         len = (l == bad_line) ? bad_len : TH_TOTAL;
         send_line(l, 0, len, len, nlines, early, stuck && (l == bad_line));
      end
   endtask

   task automatic clear();
      mm_cnt = 0; err_count = 0; err_bad = 0; fs_count = 0; fs_bad = 0; mm_msg = "";
   endtask

   task automatic test_reset();
      clear();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1'($urandom), 1'($urandom), 3'($urandom));
         checks++;
         if ({PixelX, PixelY, PixelValid, rgb_out, FrameStart, Locked, SyncErr} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {PixelX, PixelY, PixelValid, rgb_out, FrameStart, Locked, SyncErr});
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 3'd0);
      checks++;
      if (Locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b required 0", Locked); end
      checks++;
      if (mm_cnt !== 0) begin failures++; $display("FAIL reset_model: mismatches=%0d required 0; %s", mm_cnt, mm_msg); end
   endtask

   task automatic test_lock();
      clear();
      send_frame(TV_TOTAL, -1, 0, 0, 0);
      pix(0, 0, TH_TOTAL, TV_TOTAL, 0, 0, 3'($urandom));
      checks++;
      if (Locked !== 1'b0) begin failures++; $display("FAIL lock_early: got %b required 0", Locked); end
      pix(0, 1, TH_TOTAL, TV_TOTAL, 0, 0, 3'($urandom));
      checks++;
      if (Locked !== 1'b1) begin failures++; $display("FAIL lock_rise: got %b required 1", Locked); end
      send_line(0, 2, TH_TOTAL, TH_TOTAL, TV_TOTAL, 0, 0);
      for (int l = 1; l < TV_TOTAL; l++) send_line(l, 0, TH_TOTAL, TH_TOTAL, TV_TOTAL, 0, 0);
      fs_count = 0; fs_bad = 0;
      send_frame(TV_TOTAL, -1, 0, 0, 0);
      checks++;
      if (fs_count !== 1 || fs_bad !== 0) begin
         failures++; $display("FAIL lock_framestart: got pulses=%0d bad=%0d required 1/0", fs_count, fs_bad);
      end
      checks++;
      if (mm_cnt !== 0) begin failures++; $display("FAIL lock_model: mismatches=%0d required 0; %s", mm_cnt, mm_msg); end
   endtask

   task automatic test_last_pixel();
      int ll, lc;
      clear();
      ll = VY0 + TV_VIS - 1;
      lc = HX0 + TH_VIS - 1;
      for (int l = 0; l < ll; l++) send_line(l, 0, TH_TOTAL, TH_TOTAL, TV_TOTAL, 0, 0);
      send_line(ll, 0, lc, TH_TOTAL, TV_TOTAL, 0, 0);
      pix(ll, lc, TH_TOTAL, TV_TOTAL, 0, 0, 3'b101);
      pix(ll, lc + 1, TH_TOTAL, TV_TOTAL, 0, 0, 3'b010);
      checks++;
      if (PixelValid !== 1'b1 || PixelX !== 10'(TH_VIS - 1) || PixelY !== 10'(TV_VIS - 1)) begin
         failures++; $display("FAIL last_pixel_xy: got V=%b X=%0d Y=%0d required 1/%0d/%0d", PixelValid, PixelX, PixelY, TH_VIS - 1, TV_VIS - 1);
      end
      checks++;
      if (rgb_out !== 3'b101) begin failures++; $display("FAIL last_pixel_rgb: got %b required 101", rgb_out); end
      pix(ll, lc + 2, TH_TOTAL, TV_TOTAL, 0, 0, 3'b111);
      checks++;
      if (PixelValid !== 1'b0 || rgb_out !== 3'b000) begin
         failures++; $display("FAIL after_last_pixel: got V=%b rgb=%b required 0/000", PixelValid, rgb_out);
      end
      send_line(ll, lc + 3, TH_TOTAL, TH_TOTAL, TV_TOTAL, 0, 0);
      for (int l = ll + 1; l < TV_TOTAL; l++) send_line(l, 0, TH_TOTAL, TH_TOTAL, TV_TOTAL, 0, 0);
      checks++;
      if (mm_cnt !== 0) begin failures++; $display("FAIL last_pixel_model: mismatches=%0d required 0; %s", mm_cnt, mm_msg); end
   endtask

   // one faulty frame while locked, then two good frames to relock
   task automatic fault_and_relock(input string name, input int nlines, input int bad_line,
                                   input int bad_len, input bit stuck);
      clear();
      send_frame(nlines, bad_line, bad_len, stuck, 0);
      checks++;
      if (err_count !== 1 || err_bad !== 0) begin
         failures++; $display("FAIL %s_syncerr: got pulses=%0d bad=%0d required 1/0", name, err_count, err_bad);
      end
      checks++;
      if (Locked !== 1'b0) begin failures++; $display("FAIL %s_unlock: got %b required 0", name, Locked); end
      send_frame(TV_TOTAL, -1, 0, 0, 0);
      checks++;
      if (Locked !== 1'b0) begin failures++; $display("FAIL %s_measure: got %b required 0", name, Locked); end
      send_frame(TV_TOTAL, -1, 0, 0, 0);
      checks++;
      if (Locked !== 1'b1) begin failures++; $display("FAIL %s_relock: got %b required 1", name, Locked); end
      checks++;
      if (mm_cnt !== 0) begin failures++; $display("FAIL %s_model: mismatches=%0d required 0; %s", name, mm_cnt, mm_msg); end
   endtask

   task automatic test_long_line();
      fault_and_relock("long_line", TV_TOTAL, 5, TH_TOTAL + 1, 1'b0);
   endtask

   task automatic test_hsync_stuck();
      fault_and_relock("hsync_stuck", TV_TOTAL, 3, TH_TOTAL + 6, 1'b1);
   endtask

   task automatic test_long_frame();
      fault_and_relock("long_frame", TV_TOTAL + 1, -1, 0, 1'b0);
   endtask

   task automatic test_measure_fault();
      rst = 1'b1;
      tick(1'b1, 1'b1, 3'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 3'd0);
      clear();
      send_frame(TV_TOTAL, 4, TH_TOTAL - 1, 0, 0);
      checks++;
      if (err_count !== 0) begin failures++; $display("FAIL measure_fault_err: got pulses=%0d required 0", err_count); end
      send_frame(TV_TOTAL, -1, 0, 0, 0);
      checks++;
      if (Locked !== 1'b0) begin failures++; $display("FAIL measure_fault_lock: got %b required 0", Locked); end
      send_frame(TV_TOTAL, -1, 0, 0, 0);
      checks++;
      if (Locked !== 1'b1) begin failures++; $display("FAIL measure_fault_relock: got %b required 1", Locked); end
      checks++;
      if (mm_cnt !== 0) begin failures++; $display("FAIL measure_fault_model: mismatches=%0d required 0; %s", mm_cnt, mm_msg); end
   endtask

   task automatic test_vsync_early();
      clear();
      send_frame(TV_TOTAL, -1, 0, 0, 7);
      send_frame(TV_TOTAL, -1, 0, 0, 0);
      checks++;
      if (err_count !== 0 || Locked !== 1'b1) begin
         failures++; $display("FAIL vsync_early: got errs=%0d locked=%b required 0/1", err_count, Locked);
      end
      checks++;
      if (mm_cnt !== 0) begin failures++; $display("FAIL vsync_early_model: mismatches=%0d required 0; %s", mm_cnt, mm_msg); end
   endtask

   task automatic test_rst_mid_line();
      clear();
      for (int l = 0; l < 7; l++) send_line(l, 0, TH_TOTAL, TH_TOTAL, TV_TOTAL, 0, 0);
      send_line(7, 0, 15, TH_TOTAL, TV_TOTAL, 0, 0);
      checks++;
      if (PixelValid !== 1'b1) begin failures++; $display("FAIL rst_mid_prior_valid: got %b required 1", PixelValid); end
      rst = 1'b1;
      pix(7, 15, TH_TOTAL, TV_TOTAL, 0, 0, 3'($urandom));
      rst = 1'b0;
      checks++;
      if ({PixelX, PixelY, PixelValid, rgb_out, FrameStart, Locked, SyncErr} !== 27'd0) begin
         failures++; $display("FAIL rst_mid_outputs: got %h required 0", {PixelX, PixelY, PixelValid, rgb_out, FrameStart, Locked, SyncErr});
      end
      send_line(7, 16, TH_TOTAL, TH_TOTAL, TV_TOTAL, 0, 0);
      for (int l = 8; l < TV_TOTAL; l++) send_line(l, 0, TH_TOTAL, TH_TOTAL, TV_TOTAL, 0, 0);
      send_frame(TV_TOTAL, -1, 0, 0, 0);
      checks++;
      if (Locked !== 1'b0) begin failures++; $display("FAIL rst_mid_measure: got %b required 0", Locked); end
      send_frame(TV_TOTAL, -1, 0, 0, 0);
      checks++;
      if (Locked !== 1'b1) begin failures++; $display("FAIL rst_mid_relock: got %b required 1", Locked); end
      checks++;
      if (mm_cnt !== 0) begin failures++; $display("FAIL rst_mid_model: mismatches=%0d required 0; %s", mm_cnt, mm_msg); end
   endtask

   task automatic test_random();
      clear();
      for (int f = 0; f < 10; f++) begin
         int r, nlines, bad_line, bad_len, early;
         bit stuck;
         r = $urandom_range(0, 9);
         nlines = (r == 0) ? TV_TOTAL - 1 : (r == 1) ? TV_TOTAL + 1 : TV_TOTAL;
         bad_line = -1; bad_len = TH_TOTAL; stuck = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            bad_line = $urandom_range(0, nlines - 1);
            stuck = ($urandom_range(0, 4) == 0);
            if (stuck) bad_len = TH_TOTAL + 6;
            else if ($urandom_range(0, 1) == 1) bad_len = TH_TOTAL - $urandom_range(1, 3);
            else bad_len = TH_TOTAL + $urandom_range(1, 3);
         end
         early = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
         send_frame(nlines, bad_line, bad_len, stuck, early);
      end
      checks++;
      if (mm_cnt !== 0) begin failures++; $display("FAIL random_model: mismatches=%0d required 0; %s", mm_cnt, mm_msg); end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lock();
      test_last_pixel();
      test_long_line();
      test_hsync_stuck();
      test_long_frame();
      test_vsync_early();
      test_rst_mid_line();
      test_measure_fault();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  H_VIS, 640, visible pixels per line
  H_SYNC, 96, HSync low width
  H_BP, 48, horizontal back porch
  H_TOTAL, 800, clocks per line
  V_VIS, 480, visible lines
  V_SYNC, 2, VSync low width in lines
  V_BP, 33, vertical back porch
  V_TOTAL, 525, lines per frame
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
  clk  in  1  pixel clock; one input sample per clock
  rst  in  1  synchronous, active-high reset
  HSync  in  1  incoming horizontal sync, active low
  VSync  in  1  incoming vertical sync, active low
  rgb  in  3  incoming pixel colour
  PixelX  out  10  recovered column, 0..639
  PixelY  out  10  recovered row, 0..479
  PixelValid  out  1  Locked and in visible area
  rgb_out  out  3  colour for PixelX/PixelY; 0 when PixelValid low
  FrameStart  out  1  one-cycle pulse with pixel (0,0)
  Locked  out  1  timing matches parameters
  SyncErr  out  1  one-cycle pulse on timing violation while Locked

Function
REQ-003 HSync, VSync and rgb SHALL be registered once (stage 1); all outputs SHALL be registered; pin-to-output latency is 2 clocks.
REQ-004 Sync edge = stage-1 value 0 while previous stage-1 value 1.
REQ-005 hcnt (10 bits) SHALL load 0 on an HSync edge, else increment, saturating at 1023.
REQ-006 A VSync edge SHALL set flag vpend; on the next HSync edge (same-cycle counts) vcnt SHALL load 0 and vpend clear ("frame event"); other HSync edges increment vcnt, saturating at 1023.
REQ-007 FSM states: SEARCH, MEASURE, LOCKED.
REQ-008 SEARCH -> MEASURE on a frame event; no checks in SEARCH.
REQ-009 Line fault = HSync edge with hcnt != H_TOTAL-1, or hcnt reaching H_TOTAL without an edge (timeout). Frame fault = frame event with vcnt != V_TOTAL-1, or vcnt reaching V_TOTAL without a frame event.
REQ-010 MEASURE: any fault -> SEARCH, no SyncErr; fault-free frame event -> LOCKED.
REQ-011 LOCKED: any fault -> SEARCH with SyncErr pulsed 1 cycle; otherwise stay.
REQ-012 Visible window: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_VIS), i.e. 144..783; vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_VIS), i.e. 35..514.
REQ-013 PixelValid SHALL be 1 only in LOCKED within window; PixelX = hcnt-144, PixelY = vcnt-35; when PixelValid is 0, PixelX, PixelY, rgb_out SHALL be 0.
REQ-014 FrameStart SHALL pulse with PixelValid at PixelX=0, PixelY=0.
REQ-015 Locked SHALL be 1 exactly while in LOCKED; it drops the cycle SyncErr pulses, and PixelValid drops the same cycle.
REQ-016 Simultaneous VSync and HSync edges SHALL produce the frame event on that cycle.

Reset
REQ-017 On rst: stage-1 HSync/VSync = 1, stage-1 rgb = 0, hcnt = vcnt = 0, vpend = 0, state = SEARCH, all outputs 0.
REQ-018 rst mid-frame SHALL abort lock; relock needs a frame event plus one full fault-free frame.

Structure
REQ-019 Timing defaults and FSM state encoding SHALL live in shared package vga_timing_pkg, also usable by the existing generator.
REQ-020 One sub-module, sync_edge_det (stage-1 register plus falling-edge pulse), SHALL be instantiated twice (HSync, VSync).

Verification
REQ-021 rst high 3 clocks with random inputs -> every output 0, Locked 0.
REQ-022 Ideal 640x480 stream, 3 frames -> Locked rises 2 clocks after second frame event's HSync edge at the pins; frame 3 FrameStart with X=0,Y=0.
REQ-023 Locked, rgb=3'b101 at hcnt 783 of line 514 -> 2 clocks later PixelX=639, PixelY=479, rgb_out=3'b101, PixelValid 1; next clock PixelValid 0, rgb_out 0.
REQ-024 Locked, one line 801 clocks -> SyncErr one pulse, Locked 0, PixelValid 0; relock after 2 more good frame events.
REQ-025 Locked, HSync held high -> SyncErr when hcnt reaches 800; frame of 526 lines -> SyncErr at vcnt 525.
REQ-026 Fault during MEASURE -> SEARCH, SyncErr stays 0; rst asserted mid-visible line -> outputs 0 next clock.
